snake_collision_gen: RTL and testbench

Snake-game event source that produces the single-cycle `goodColl` / `badColl` pulses consumed by the score path. It owns the snake head position, a body history of up to 15 segments, and the apple position, and advances the snake one cell per `step_tick` on a 16x8 grid. Outputs are registered pulses that feed the score edge detector / tracker directly, with no debouncing.

---
 rtl/snake_collision_gen.sv | 179 +++++++++++++++++
 tb/tb_snake_collision_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_collision_gen.sv
// snake_collision_gen: snake game event source on a 16x8 grid.
// Advances the head one cell per processed step, tracks up to MAX_LEN body
// segments and an LFSR-placed apple, and emits registered single-cycle
// goodColl (apple eaten) / badColl (wall or self hit) pulses.
module snake_collision_gen #(
   parameter logic [7:0] SEED    = 8'hA5,
   parameter int         MAX_LEN = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       step_tick,
   input  logic       dir_vld,
   input  logic [1:0] dir_i,
   output logic       goodColl,
   output logic       badColl,
   output logic [3:0] head_x,
   output logic [2:0] head_y,
   output logic [3:0] apple_x,
   output logic [2:0] apple_y,
   output logic       apple_vld,
   output logic [3:0] length,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_APPLE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   localparam logic [3:0] HOME_X   = 4'd8;
   localparam logic [2:0] HOME_Y   = 3'd4;
   localparam logic [3:0] APPLE0_X = 4'd12;
   localparam logic [2:0] APPLE0_Y = 3'd4;
   localparam logic [1:0] D_RIGHT  = 2'd0;

   state_t     st;
   logic [7:0] lfsr;
   logic [1:0] cur_dir;
   logic [1:0] pend_dir;
   logic       step_pend;
   logic [3:0] body_x [MAX_LEN];
   logic [2:0] body_y [MAX_LEN];

   logic [4:0] nx, ny;
   logic       wall_hit, self_hit, apple_hit, cand_hit, do_step;
   logic [3:0] cand_x;
   logic [2:0] cand_y;
   logic       fb;

   assign state  = st;
   assign fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign cand_x = lfsr[3:0];
   assign cand_y = lfsr[6:4];

   // Next head in 5-bit two's complement so that -1 and 16/8 are visible as out-of-grid
   always_comb begin
      nx = {1'b0, head_x};
      ny = {2'b00, head_y};
      case (pend_dir)
         2'd0:    nx = nx + 5'd1;
         2'd1:    ny = ny + 5'd1;
         2'd2:    nx = nx - 5'd1;
         default: ny = ny - 5'd1;
      endcase
   end

   assign wall_hit  = nx[4] | ny[4] | ny[3];
   assign apple_hit = apple_vld && (nx[3:0] == apple_x) && (ny[2:0] == apple_y);
   assign do_step   = (st == S_RUN) && (step_tick || step_pend);

   // Occupancy compares against the active body: next head for self hit, LFSR candidate for apple placement
   always_comb begin
      self_hit = 1'b0;
      cand_hit = (cand_x == head_x) && (cand_y == head_y);
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(length)) begin
            if (body_x[i] == nx[3:0] && body_y[i] == ny[2:0]) self_hit = 1'b1;
            if (body_x[i] == cand_x && body_y[i] == cand_y)   cand_hit = 1'b1;
         end
      end
   end

   // Game FSM with registered pulses, head/body/apple state and free-running LFSR
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         lfsr      <= SEED;
         cur_dir   <= D_RIGHT;
         pend_dir  <= D_RIGHT;
         step_pend <= 1'b0;
         head_x    <= HOME_X;
         head_y    <= HOME_Y;
         apple_x   <= APPLE0_X;
         apple_y   <= APPLE0_Y;
         apple_vld <= 1'b1;
         length    <= 4'd0;
         goodColl  <= 1'b0;
         badColl   <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            body_x[i] <= 4'd0;
            body_y[i] <= 3'd0;
         end
      end else begin
         lfsr     <= {lfsr[6:0], fb};
         goodColl <= 1'b0;
         badColl  <= 1'b0;

         // Reversals are dropped; a step in this same cycle still uses the old pending value
         if (dir_vld && (dir_i != (cur_dir ^ 2'd2)))
            pend_dir <= dir_i;

         case (st)
            S_IDLE: begin
               if (start) st <= S_RUN;
            end

            S_RUN: begin
               if (do_step) begin
                  step_pend <= 1'b0;
                  cur_dir   <= pend_dir;
                  if (wall_hit || self_hit) begin
                     badColl <= 1'b1;
                     st      <= S_OVER;
                  end else begin
                     for (int i = MAX_LEN - 1; i > 0; i--) begin
                        body_x[i] <= body_x[i-1];
                        body_y[i] <= body_y[i-1];
                     end
                     body_x[0] <= head_x;
                     body_y[0] <= head_y;
                     head_x    <= nx[3:0];
                     head_y    <= ny[2:0];
                     if (apple_hit) begin
                        goodColl  <= 1'b1;
                        apple_vld <= 1'b0;
                        st        <= S_APPLE;
                        if (length != 4'(MAX_LEN)) length <= length + 4'd1;
                     end
                  end
               end
            end

            S_APPLE: begin
               // One-deep step memory; extra ticks while set are simply absorbed
               if (step_tick) step_pend <= 1'b1;
               if (!cand_hit) begin
                  apple_x   <= cand_x;
                  apple_y   <= cand_y;
                  apple_vld <= 1'b1;
                  st        <= S_RUN;
               end
            end

            default: begin
               if (start) begin
                  head_x    <= HOME_X;
                  head_y    <= HOME_Y;
                  cur_dir   <= D_RIGHT;
                  pend_dir  <= D_RIGHT;
                  step_pend <= 1'b0;
                  apple_x   <= APPLE0_X;
                  apple_y   <= APPLE0_Y;
                  apple_vld <= 1'b1;
                  length    <= 4'd0;
                  for (int i = 0; i < MAX_LEN; i++) begin
                     body_x[i] <= 4'd0;
                     body_y[i] <= 3'd0;
                  end
                  st <= S_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_collision_gen.sv
// Directed bench for snake_collision_gen: reset, apple eat, wall, reversal,
// self hit by steering, and restart with a step pended in APPLE.
module tb_snake_collision_gen;

   logic       clk = 1'b0;
   logic       rst, start, step_tick, dir_vld;
   logic [1:0] dir_i;
   logic       goodColl, badColl, apple_vld;
   logic [3:0] head_x, apple_x, length;
   logic [2:0] head_y, apple_y;
   logic [1:0] state;

   int n_chk = 0;
   int n_fail = 0;

   // Bench-side snake model
   int mhx, mhy, mlen, mdir, mpend;
   int mbx[15];
   int mby[15];

   snake_collision_gen dut (
      .clk(clk), .rst(rst), .start(start), .step_tick(step_tick),
      .dir_vld(dir_vld), .dir_i(dir_i), .goodColl(goodColl), .badColl(badColl),
      .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
      .apple_vld(apple_vld), .length(length), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic model_init;
      mhx = 8; mhy = 4; mlen = 0; mdir = 0; mpend = 0;
      for (int i = 0; i < 15; i++) begin mbx[i] = 0; mby[i] = 0; end
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; start = 1'b0; step_tick = 1'b0; dir_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (state == 2'd1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL wait_run: state=%0d, required 1 within 400 cycles", state);
      end
   endtask

   function automatic int pick_dir(input int tx, input int ty);
      int best, bs, nx, ny, s;
      bit ok;
      best = -1; bs = 1000;
      for (int d = 0; d < 4; d++) begin
         if (d == (mdir ^ 2)) continue;
         nx = mhx + ((d == 0) ? 1 : (d == 2) ? -1 : 0);
         ny = mhy + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
         ok = (nx >= 0 && nx <= 15 && ny >= 0 && ny <= 7);
         for (int i = 0; i < mlen; i++) if (mbx[i] == nx && mby[i] == ny) ok = 1'b0;
         if (!ok) continue;
         s = ((nx > tx) ? nx - tx : tx - nx) + ((ny > ty) ? ny - ty : ty - ny);
         if (s < bs) begin bs = s; best = d; end
      end
      return best;
   endfunction

   // One processed step, optionally preceded by a direction request; checked against the model
   task automatic step_dir(input int d, input bit drv, input string tag, output bit ate);
      bit ok, hit, eat, av;
      int ax, ay, nx, ny, es;
      ate = 1'b0;
      wait_run(ok);
      if (!ok) return;
      ax = int'(apple_x); ay = int'(apple_y); av = apple_vld;
      if (drv) begin
         if (d != (mdir ^ 2)) mpend = d;
         dir_i = 2'(d); dir_vld = 1'b1;
         @(negedge clk);
         dir_vld = 1'b0;
      end
      step_tick = 1'b1;
      @(negedge clk);
      step_tick = 1'b0;
      nx = mhx + ((mpend == 0) ? 1 : (mpend == 2) ? -1 : 0);
      ny = mhy + ((mpend == 1) ? 1 : (mpend == 3) ? -1 : 0);
      hit = (nx < 0 || nx > 15 || ny < 0 || ny > 7);
      for (int i = 0; i < mlen; i++) if (mbx[i] == nx && mby[i] == ny) hit = 1'b1;
      eat = !hit && av && nx == ax && ny == ay;
      mdir = mpend;
      if (!hit) begin
         for (int i = 14; i > 0; i--) begin mbx[i] = mbx[i-1]; mby[i] = mby[i-1]; end
         mbx[0] = mhx; mby[0] = mhy;
         mhx = nx; mhy = ny;
         if (eat && mlen < 15) mlen++;
      end
      es = hit ? 3 : (eat ? 2 : 1);
      n_chk++; if (head_x !== 4'(mhx)) begin n_fail++; $display("FAIL %s head_x: got %0d, required %0d", tag, head_x, mhx); end
      n_chk++; if (head_y !== 3'(mhy)) begin n_fail++; $display("FAIL %s head_y: got %0d, required %0d", tag, head_y, mhy); end
      n_chk++; if (goodColl !== eat)   begin n_fail++; $display("FAIL %s goodColl: got %b, required %b", tag, goodColl, eat); end
      n_chk++; if (badColl !== hit)    begin n_fail++; $display("FAIL %s badColl: got %b, required %b", tag, badColl, hit); end
      n_chk++; if (length !== 4'(mlen)) begin n_fail++; $display("FAIL %s length: got %0d, required %0d", tag, length, mlen); end
      n_chk++; if (state !== 2'(es))   begin n_fail++; $display("FAIL %s state: got %0d, required %0d", tag, state, es); end
      ate = eat;
   endtask

   // After an eat: pulse width, bounded wait for the new apple, apple clear of the snake
   task automatic after_eat(input string tag);
      bit seen, clash;
      @(negedge clk);
      n_chk++; if (goodColl !== 1'b0) begin n_fail++; $display("FAIL %s pulse_width: goodColl=%b, required 0", tag, goodColl); end
      seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (apple_vld === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      n_chk++;
      if (!seen) begin
         n_fail++; $display("FAIL %s apple_timeout: apple_vld=%b, required 1 within 400 cycles", tag, apple_vld);
      end else begin
         clash = (int'(apple_x) == mhx && int'(apple_y) == mhy);
         for (int i = 0; i < mlen; i++) if (int'(apple_x) == mbx[i] && int'(apple_y) == mby[i]) clash = 1'b1;
         n_chk++; if (clash) begin n_fail++; $display("FAIL %s apple_on_snake: apple (%0d,%0d), required free cell", tag, apple_x, apple_y); end
         n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL %s state_after_apple: got %0d, required 1", tag, state); end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; step_tick = 1'b0; dir_vld = 1'b0; dir_i = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_chk++; if (head_x !== 4'd8 || head_y !== 3'd4) begin n_fail++; $display("FAIL reset_head: got (%0d,%0d), required (8,4)", head_x, head_y); end
      n_chk++; if (apple_x !== 4'd12 || apple_y !== 3'd4) begin n_fail++; $display("FAIL reset_apple: got (%0d,%0d), required (12,4)", apple_x, apple_y); end
      n_chk++; if (apple_vld !== 1'b1) begin n_fail++; $display("FAIL reset_apple_vld: got %b, required 1", apple_vld); end
      n_chk++; if (length !== 4'd0) begin n_fail++; $display("FAIL reset_length: got %0d, required 0", length); end
      n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state); end
      n_chk++; if (goodColl !== 1'b0 || badColl !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b, required 00", goodColl, badColl); end
   endtask

   task automatic test_idle;
      step_tick = 1'b1; @(negedge clk); step_tick = 1'b0;
      n_chk++; if (head_x !== 4'd8 || state !== 2'd0) begin n_fail++; $display("FAIL idle_step: head_x=%0d state=%0d, required 8 and 0", head_x, state); end
      start = 1'b1; step_tick = 1'b1; @(negedge clk); start = 1'b0; step_tick = 1'b0;
      n_chk++; if (state !== 2'd1 || head_x !== 4'd8) begin n_fail++; $display("FAIL start_with_step: state=%0d head_x=%0d, required 1 and 8", state, head_x); end
      model_init();
   endtask

   task automatic test_apple_eat;
      int xs[4];
      bit ate;
      xs = '{9, 10, 11, 12};
      for (int s = 0; s < 4; s++) begin
         step_dir(0, 1'b0, "apple_eat", ate);
         n_chk++; if (head_x !== 4'(xs[s])) begin n_fail++; $display("FAIL apple_x_seq: got %0d, required %0d", head_x, xs[s]); end
      end
      n_chk++; if (goodColl !== 1'b1 || length !== 4'd1) begin n_fail++; $display("FAIL apple_pulse: goodColl=%b length=%0d, required 1 and 1", goodColl, length); end
      n_chk++; if (apple_vld !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL apple_pending: apple_vld=%b state=%0d, required 0 and 2", apple_vld, state); end
      after_eat("apple_eat");
      n_chk++;
      if ((apple_x === 4'd12 && apple_y === 3'd4) || (apple_x === 4'd11 && apple_y === 3'd4)) begin
         n_fail++; $display("FAIL apple_new_cell: got (%0d,%0d), required not (12,4)/(11,4)", apple_x, apple_y);
      end
   endtask

   task automatic test_reversal;
      bit ate;
      do_reset(); do_start(); model_init();
      step_dir(2, 1'b1, "reversal", ate);
      n_chk++; if (head_x !== 4'd9 || head_y !== 3'd4 || badColl !== 1'b0) begin n_fail++; $display("FAIL reversal_drop: head (%0d,%0d) bad=%b, required (9,4) 0", head_x, head_y, badColl); end
      // direction request and step in the same cycle: step still goes RIGHT
      dir_i = 2'd1; dir_vld = 1'b1; step_tick = 1'b1;
      @(negedge clk);
      dir_vld = 1'b0; step_tick = 1'b0;
      n_chk++; if (head_x !== 4'd10 || head_y !== 3'd4) begin n_fail++; $display("FAIL dir_same_cycle: head (%0d,%0d), required (10,4)", head_x, head_y); end
      step_tick = 1'b1; @(negedge clk); step_tick = 1'b0;
      n_chk++; if (head_x !== 4'd10 || head_y !== 3'd5) begin n_fail++; $display("FAIL dir_next_step: head (%0d,%0d), required (10,5)", head_x, head_y); end
   endtask

   task automatic test_wall;
      int ys[4];
      bit ate;
      ys = '{3, 2, 1, 0};
      do_reset(); do_start(); model_init();
      for (int s = 0; s < 4; s++) begin
         step_dir(3, (s == 0), "wall", ate);
         n_chk++; if (head_y !== 3'(ys[s]) || badColl !== 1'b0) begin n_fail++; $display("FAIL wall_y_seq: y=%0d bad=%b, required %0d 0", head_y, badColl, ys[s]); end
      end
      step_dir(3, 1'b0, "wall_hit", ate);
      n_chk++; if (badColl !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL wall_hit: bad=%b state=%0d, required 1 3", badColl, state); end
      n_chk++; if (head_x !== 4'd8 || head_y !== 3'd0) begin n_fail++; $display("FAIL wall_head_hold: (%0d,%0d), required (8,0)", head_x, head_y); end
      @(negedge clk);
      n_chk++; if (badColl !== 1'b0) begin n_fail++; $display("FAIL wall_pulse_width: bad=%b, required 0", badColl); end
      for (int t = 0; t < 2; t++) begin
         step_tick = 1'b1; @(negedge clk); step_tick = 1'b0;
         n_chk++;
         if (badColl !== 1'b0 || goodColl !== 1'b0 || head_y !== 3'd0 || state !== 2'd3) begin
            n_fail++; $display("FAIL over_hold: bad=%b good=%b y=%0d state=%0d, required 0 0 0 3", badColl, goodColl, head_y, state);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_self_hit;
      bit ok, ate;
      int d, guard, run;
      do_reset(); do_start(); model_init();
      guard = 0;
      while (mlen < 4 && guard < 300) begin
         guard++;
         wait_run(ok); if (!ok) break;
         d = pick_dir(int'(apple_x), int'(apple_y));
         if (d < 0) break;
         step_dir(d, 1'b1, "steer", ate);
         if (badColl) break;
         if (ate) after_eat("steer");
      end
      n_chk++; if (mlen < 4 || state === 2'd3) begin n_fail++; $display("FAIL self_grow: length=%0d state=%0d, required >=4 and running", mlen, state); end
      // head to the left edge, then run straight right until the whole body is in one row
      guard = 0;
      while (mhx > 1 && guard < 100 && state !== 2'd3) begin
         guard++;
         wait_run(ok); if (!ok) break;
         d = pick_dir(0, 2); if (d < 0) break;
         step_dir(d, 1'b1, "to_left", ate);
         if (ate) after_eat("to_left");
      end
      run = 0; guard = 0;
      while (guard < 40 && state !== 2'd3) begin
         if (run >= mlen && mhy <= 6 && mhx >= 1 && mhx <= 14) break;
         guard++;
         wait_run(ok); if (!ok) break;
         d = pick_dir(15, 2); if (d < 0) break;
         step_dir(d, 1'b1, "run_right", ate);
         run = (d == 0) ? run + 1 : 0;
         if (ate) after_eat("run_right");
      end
      n_chk++; if (run < mlen || mdir != 0) begin n_fail++; $display("FAIL self_setup: run=%0d length=%0d, required run>=length heading right", run, mlen); end
      step_dir(1, 1'b1, "loop_down", ate); if (ate) after_eat("loop_down");
      step_dir(2, 1'b1, "loop_left", ate); if (ate) after_eat("loop_left");
      step_dir(3, 1'b1, "loop_up", ate);
      n_chk++; if (badColl !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL self_hit: bad=%b state=%0d, required 1 3", badColl, state); end
   endtask

   task automatic test_restart;
      bit ate, bad_seen;
      @(negedge clk);
      do_start();
      n_chk++; if (state !== 2'd1 || length !== 4'd0) begin n_fail++; $display("FAIL restart_state: state=%0d length=%0d, required 1 0", state, length); end
      n_chk++; if (head_x !== 4'd8 || head_y !== 3'd4) begin n_fail++; $display("FAIL restart_head: (%0d,%0d), required (8,4)", head_x, head_y); end
      n_chk++; if (apple_x !== 4'd12 || apple_y !== 3'd4 || apple_vld !== 1'b1) begin n_fail++; $display("FAIL restart_apple: (%0d,%0d) vld=%b, required (12,4) 1", apple_x, apple_y, apple_vld); end
      model_init();
      for (int s = 0; s < 4; s++) step_dir(0, 1'b0, "restart_eat", ate);
      n_chk++; if (state !== 2'd2 || head_x !== 4'd12) begin n_fail++; $display("FAIL restart_eat: state=%0d x=%0d, required 2 12", state, head_x); end
      // two ticks while the apple is being placed: only one step may result
      step_tick = 1'b1; @(negedge clk);
      step_tick = 1'b1; @(negedge clk);
      step_tick = 1'b0;
      bad_seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (badColl === 1'b1) bad_seen = 1'b1;
         if (head_x === 4'd13) break;
         @(negedge clk);
      end
      n_chk++; if (head_x !== 4'd13 || head_y !== 3'd4) begin n_fail++; $display("FAIL pend_step: head (%0d,%0d), required (13,4)", head_x, head_y); end
      repeat (20) begin
         @(negedge clk);
         if (badColl === 1'b1) bad_seen = 1'b1;
      end
      n_chk++; if (head_x !== 4'd13 || state !== 2'd1) begin n_fail++; $display("FAIL pend_one_deep: x=%0d state=%0d, required 13 1", head_x, state); end
      n_chk++; if (bad_seen) begin n_fail++; $display("FAIL pend_no_bad: badColl seen 1, required 0"); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_apple_eat();
      test_reversal();
      test_wall();
      test_self_hit();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
